// File: rtl/gsim_pkg.sv
// ----------------------------------------------------------------------------
// gsim_pkg
// Shared definitions for the GSIM unknown-register sequencer.
//   N                 : unknowns per vector (register depth)
//   SH1/SH4/SH5/HOLD  : shift-control encodings driven on sh_ctrl
//   state_t           : sequencer FSM state encoding
// ----------------------------------------------------------------------------
package gsim_pkg;

   localparam int N = 16;

   localparam logic [1:0] SH1  = 2'b00;
   localparam logic [1:0] SH4  = 2'b01;
   localparam logic [1:0] SH5  = 2'b10;
   localparam logic [1:0] HOLD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_CALC = 3'd2,
      S_WAIT = 3'd3,
      S_OUT  = 3'd4
   } state_t;

endpackage

// File: rtl/gsim_seq.sv
// ----------------------------------------------------------------------------
// gsim_seq
// Sequencer for the 16-entry circular unknown register of the GSIM solver.
// Loads the initial vector, runs ITER Gauss-Seidel sweeps, then streams the
// solution out. Carries no data; only steers the register and handshakes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a solve (sampled in IDLE only)
//   in_valid/in_ready   initial-vector stream handshake
//   in_sel              register IN source: 0 external, 1 arithmetic result
//   calc_start          one-cycle pulse, taps hold current row's neighbours
//   calc_valid          arithmetic result ready
//   sh_ctrl, sh_load    register shift command / write entry 15
//   out_valid/out_ready solution stream handshake (data = entry 15)
//   out_idx             index of the unknown currently on entry 15
//   iter_cnt            completed sweeps
//   busy, done          not idle / pulse after the last output beat
//   state_dbg           current FSM state
//
// Handshakes: a beat transfers in a cycle where valid and ready are both
// high; the register command for that beat is issued in the same cycle.
// ----------------------------------------------------------------------------
module gsim_seq
   import gsim_pkg::*;
#(
   parameter int ITER = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       in_sel,
   output logic       calc_start,
   input  logic       calc_valid,
   output logic [1:0] sh_ctrl,
   output logic       sh_load,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_idx,
   output logic [7:0] iter_cnt,
   output logic       busy,
   output logic       done,
   output state_t     state_dbg
);

   localparam logic [3:0] LAST   = 4'(N - 1);
   localparam logic [7:0] ITER_L = 8'(ITER);

   state_t     state;
   logic [3:0] row;
   logic [3:0] out_k;
   logic [7:0] iter_next;

   // Saturating sweep count as it will be after the current row completes.
   assign iter_next = (iter_cnt == ITER_L) ? iter_cnt : iter_cnt + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         row      <= 4'd0;
         out_k    <= 4'd0;
         iter_cnt <= 8'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               row      <= 4'd0;
               out_k    <= 4'd0;
               iter_cnt <= 8'd0;
               if (start) state <= S_LOAD;
            end
            S_LOAD: begin
               if (in_valid) begin
                  row <= row + 4'd1;
                  if (row == LAST) state <= S_CALC;
               end
            end
            S_CALC: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (calc_valid) begin
                  row <= row + 4'd1;
                  if (row == LAST) begin
                     iter_cnt <= iter_next;
                     state    <= (iter_next == ITER_L) ? S_OUT : S_CALC;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_k <= out_k + 4'd1;
                  if (out_k == LAST) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Status decodes from registered state only.
   assign in_ready   = (state == S_LOAD);
   assign calc_start = (state == S_CALC);
   assign out_valid  = (state == S_OUT);
   assign busy       = (state != S_IDLE);
   assign in_sel     = (state == S_WAIT);
   assign state_dbg  = state;

   // Entry 15 holds x15 when OUT begins, so beat k carries x[(15+k) mod 16].
   // Forced to 0 outside OUT so idle/reset outputs are all zero.
   assign out_idx = out_valid ? (out_k + LAST) : 4'd0;

   // Register commands apply in the accepting cycle.
   always_comb begin
      sh_ctrl = HOLD;
      sh_load = 1'b0;
      case (state)
         S_LOAD: if (in_valid) begin
            sh_ctrl = SH1;
            sh_load = 1'b1;
         end
         S_WAIT: if (calc_valid) begin
            sh_ctrl = SH1;
            sh_load = 1'b1;
         end
         S_OUT: if (out_ready) begin
            sh_ctrl = SH1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gsim_seq.sv
module tb_gsim_seq;
   import gsim_pkg::*;

   localparam int ITER_T = 2;
   localparam int W      = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, in_valid, calc_valid, out_ready;
   logic       in_ready, in_sel, calc_start, sh_load, out_valid, busy, done;
   logic [1:0] sh_ctrl;
   logic [3:0] out_idx;
   logic [7:0] iter_cnt;
   state_t     state_dbg;

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   gsim_seq #(.ITER(ITER_T)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .calc_start(calc_start), .calc_valid(calc_valid),
      .sh_ctrl(sh_ctrl), .sh_load(sh_load),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .iter_cnt(iter_cnt), .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Event word: kind(3) sh_ctrl(2) load(1) sel(1) valid/busy(1) idx(4) iter(8)
   // kind 1 = register command, 2 = calc_start pulse, 3 = done pulse
   function automatic logic [W-1:0] mk(input logic [2:0] kind, input logic [1:0] sh,
                                       input logic ld, input logic sel, input logic ov,
                                       input logic [3:0] idx, input logic [7:0] it);
      return {kind, sh, ld, sel, ov, idx, it};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] act;
      logic [2:0]   kind;
      if (!rst && (sh_ctrl != HOLD || sh_load || calc_start || done)) begin
         kind = done ? 3'd3 : (calc_start ? 3'd2 : 3'd1);
         act  = mk(kind, sh_ctrl, sh_load, in_sel, done ? busy : out_valid, out_idx, iter_cnt);
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %0h expected none at %0t", act, $time);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (act !== e) begin
               n_err++;
               $display("FAIL event: got %0h expected %0h at %0t", act, e, $time);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},   in_ready,   0);
      check({tag, "_in_sel"},     in_sel,     0);
      check({tag, "_calc_start"}, calc_start, 0);
      check({tag, "_sh_ctrl"},    sh_ctrl,    32'h3);
      check({tag, "_sh_load"},    sh_load,    0);
      check({tag, "_out_valid"},  out_valid,  0);
      check({tag, "_out_idx"},    out_idx,    0);
      check({tag, "_iter_cnt"},   iter_cnt,   0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_done"},       done,       0);
      check({tag, "_state"},      state_dbg,  S_IDLE);
   endtask

   // One solve. lat: cycles from calc_start to calc_valid (>=1).
   // gaps: in_valid low every 3rd load cycle. rand_out: 50% out_ready.
   // abort: async reset in WAIT of row 7, sweep 1. spur: drive ignored inputs.
   task automatic run_solve(input int lat, input bit gaps, input bit rand_out,
                            input bit abort, input bit spur);
      int beat, c, k, guard;
      start = 1'b1;
      cyc();
      start = 1'b0;
      beat = 0;
      c = 0;
      while (beat < 16) begin
         if (gaps && (c % 3 == 2)) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            exp_q.push_back(mk(3'd1, SH1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
            beat++;
         end
         c++;
         cyc();
      end
      in_valid = 1'b0;
      for (int it = 0; it < ITER_T; it++) begin
         for (int r = 0; r < 16; r++) begin
            exp_q.push_back(mk(3'd2, HOLD, 1'b0, 1'b0, 1'b0, 4'd0, 8'(it)));
            calc_valid = spur;
            in_valid   = spur;
            out_ready  = spur;
            start      = spur;
            cyc();
            calc_valid = 1'b0;
            in_valid   = 1'b0;
            out_ready  = 1'b0;
            start      = 1'b0;
            if (abort && it == 1 && r == 7) begin
               check("abort_iter_cnt", iter_cnt, 1);
               check("abort_state", state_dbg, S_WAIT);
               #2 rst = 1'b1;
               #1 check_reset_outputs("abort");
               cyc();
               rst = 1'b0;
               check("abort_queue_empty", exp_q.size(), 0);
               return;
            end
            for (int w = 1; w < lat; w++) begin
               in_valid  = spur;
               out_ready = spur;
               cyc();
            end
            in_valid   = 1'b0;
            out_ready  = 1'b0;
            calc_valid = 1'b1;
            exp_q.push_back(mk(3'd1, SH1, 1'b1, 1'b1, 1'b0, 4'd0, 8'(it)));
            cyc();
            calc_valid = 1'b0;
         end
         check("sweep_iter_cnt", iter_cnt, it + 1);
      end
      k = 0;
      guard = 0;
      while (k < 16 && guard < 400) begin
         logic rdy;
         rdy = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = rdy;
         #1;
         check("out_valid", out_valid, 1);
         check("out_idx", out_idx, (15 + k) % 16);
         if (rdy) begin
            exp_q.push_back(mk(3'd1, SH1, 1'b0, 1'b0, 1'b1, 4'((15 + k) % 16), 8'(ITER_T)));
            k++;
         end
         guard++;
         cyc();
      end
      check("out_beats", k, 16);
      out_ready = 1'b0;
      exp_q.push_back(mk(3'd3, HOLD, 1'b0, 1'b0, 1'b0, 4'd0, 8'(ITER_T)));
      cyc();
      check("post_done", done, 0);
      check("post_busy", busy, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      start = 1'b0; in_valid = 1'b0; calc_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst = 1'b0;
      // Ignored handshakes in IDLE
      in_valid = 1'b1; calc_valid = 1'b1; out_ready = 1'b1;
      cyc();
      check("idle_ignore_state", state_dbg, S_IDLE);
      in_valid = 1'b0; calc_valid = 1'b0; out_ready = 1'b0;

      // Asynchronous reset mid-LOAD while a load command is active
      start = 1'b1;
      cyc();
      start = 1'b0;
      in_valid = 1'b1;
      #1 check("preload_sh_ctrl", sh_ctrl, SH1);
      check("preload_in_ready", in_ready, 1);
      #1 rst = 1'b1;
      #1 check_reset_outputs("async");
      in_valid = 1'b0;
      cyc();
      rst = 1'b0;

      run_solve(3, 1'b1, 1'b0, 1'b0, 1'b1);
      run_solve(1, 1'b0, 1'b1, 1'b0, 1'b1);
      run_solve(2, 1'b0, 1'b0, 1'b1, 1'b0);
      run_solve(1, 1'b1, 1'b1, 1'b0, 1'b0);

      repeat (3) cyc();
      check("final_queue_empty", exp_q.size(), 0);
      check("final_busy", busy, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
